// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC/nPC pair and IF/ID pipeline register.
// Applies the control-transfer handler's nPC selection and IF/ID flush,
// inserts a single boot bubble after reset, and holds on hazard stalls.
module fetch_pc_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               R,
    input  logic               LE,
    input  logic [1:0]         nPC_sel,
    input  logic               IF_ID_R,
    input  logic [ADDR_W-1:0]  TAG,
    input  logic [ADDR_W-1:0]  ALU_TA,
    input  logic [INSTR_W-1:0] IM_DATA,
    output logic [ADDR_W-1:0]  IM_ADDR,
    output logic [ADDR_W-1:0]  PC_out,
    output logic [ADDR_W-1:0]  nPC_out,
    output logic [INSTR_W-1:0] IF_ID_INSTR,
    output logic [ADDR_W-1:0]  IF_ID_PC,
    output logic [ADDR_W-1:0]  IF_ID_nPC,
    output logic               IF_ID_VALID,
    output logic               DS_FLAG,
    output logic               ALIGN_ERR
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  npc_q, npc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [ADDR_W-1:0]  if_npc_q, if_npc_d;
    logic               if_valid_q, if_valid_d;
    logic               ds_q, ds_d;
    logic               align_err_q, align_err_d;

    logic [ADDR_W-1:0]  npc_next;
    logic               redirect;
    logic               misalign;

    // Next-nPC selection; targets are word-aligned before use, code 11 falls back to nPC+4.
    always_comb begin
        npc_next = npc_q + ADDR_W'(4);
        redirect = 1'b0;
        misalign = 1'b0;
        case (nPC_sel)
            2'b01: begin
                npc_next = {TAG[ADDR_W-1:2], 2'b00};
                redirect = 1'b1;
                misalign = (TAG[1:0] != 2'b00);
            end
            2'b10: begin
                npc_next = {ALU_TA[ADDR_W-1:2], 2'b00};
                redirect = 1'b1;
                misalign = (ALU_TA[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // FSM next state plus PC/nPC and IF/ID next values; everything holds by default.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_npc_d    = if_npc_q;
        if_valid_d  = if_valid_q;
        ds_d        = ds_q;
        align_err_d = align_err_q;

        case (state_q)
            StBoot: begin
                state_d    = StRun;
                if_instr_d = '0;
                if_valid_d = 1'b0;
                ds_d       = 1'b0;
            end
            StRun, StHold: begin
                if (LE) begin
                    state_d     = StRun;
                    pc_d        = npc_q;
                    npc_d       = npc_next;
                    if_instr_d  = IM_DATA;
                    if_pc_d     = pc_q;
                    if_npc_d    = npc_q;
                    if_valid_d  = 1'b1;
                    ds_d        = redirect && !IF_ID_R;
                    align_err_d = align_err_q | misalign;
                end else begin
                    state_d = StHold;
                end
            end
            default: state_d = StBoot;
        endcase

        // Flush wins over any load; the PC/nPC tag fields keep their old values.
        if (IF_ID_R) begin
            if_instr_d = '0;
            if_pc_d    = if_pc_q;
            if_npc_d   = if_npc_q;
            if_valid_d = 1'b0;
            ds_d       = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC + ADDR_W'(4);
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            if_npc_q    <= '0;
            if_valid_q  <= 1'b0;
            ds_q        <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_npc_q    <= if_npc_d;
            if_valid_q  <= if_valid_d;
            ds_q        <= ds_d;
            align_err_q <= align_err_d;
        end
    end

    assign IM_ADDR     = pc_q;
    assign PC_out      = pc_q;
    assign nPC_out     = npc_q;
    assign IF_ID_INSTR = if_instr_q;
    assign IF_ID_PC    = if_pc_q;
    assign IF_ID_nPC   = if_npc_q;
    assign IF_ID_VALID = if_valid_q;
    assign DS_FLAG     = ds_q;
    assign ALIGN_ERR   = align_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: two instances, one with RESET_PC=0 and
// one with RESET_PC=0xFFFFFFF8 for the wrap-around checks.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        r0, r1, le, flush;
    logic [1:0]  sel;
    logic [31:0] tag, alu;

    logic [31:0] im_data0, im_addr0, pc0, npc0, ifi0, ifp0, ifn0;
    logic        v0, ds0, ae0;
    logic [31:0] im_data1, im_addr1, pc1, npc1, ifi1, ifp1, ifn1;
    logic        v1, ds1, ae1;

    always #5 clk = ~clk;

    // Instruction memory model: word content encodes its own address.
    assign im_data0 = 32'hA000_0000 + im_addr0;
    assign im_data1 = 32'hA000_0000 + im_addr1;

    fetch_pc_unit dut0 (
        .clk(clk), .R(r0), .LE(le), .nPC_sel(sel), .IF_ID_R(flush), .TAG(tag),
        .ALU_TA(alu), .IM_DATA(im_data0), .IM_ADDR(im_addr0), .PC_out(pc0),
        .nPC_out(npc0), .IF_ID_INSTR(ifi0), .IF_ID_PC(ifp0), .IF_ID_nPC(ifn0),
        .IF_ID_VALID(v0), .DS_FLAG(ds0), .ALIGN_ERR(ae0)
    );

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .R(r1), .LE(le), .nPC_sel(sel), .IF_ID_R(flush), .TAG(tag),
        .ALU_TA(alu), .IM_DATA(im_data1), .IM_ADDR(im_addr1), .PC_out(pc1),
        .nPC_out(npc1), .IF_ID_INSTR(ifi1), .IF_ID_PC(ifp1), .IF_ID_nPC(ifn1),
        .IF_ID_VALID(v1), .DS_FLAG(ds1), .ALIGN_ERR(ae1)
    );

    typedef struct {
        int unsigned cyc;
        int          dut;
        string       nm;
        logic [31:0] pc, npc, instr, ipc, inpc;
        logic        v, ds, ae;
        bit          ifa;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Push the state expected right after the next edge, then take that edge.
    task automatic tick(input string nm, input int d, input logic [31:0] pc, npc, instr,
                        ipc, inpc, input logic v, ds, ae, input bit ifa);
        exp_t e;
        e.cyc = cyc + 1; e.dut = d; e.nm = nm;
        e.pc = pc; e.npc = npc; e.instr = instr; e.ipc = ipc; e.inpc = inpc;
        e.v = v; e.ds = ds; e.ae = ae; e.ifa = ifa;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: on the falling edge, compare every expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] apc, anpc, ai, ap, an;
            logic        av, ads, aae;
            bit          bad;
            e = q.pop_front();
            if (e.dut == 0) begin
                apc = pc0; anpc = npc0; ai = ifi0; ap = ifp0; an = ifn0;
                av = v0; ads = ds0; aae = ae0;
            end else begin
                apc = pc1; anpc = npc1; ai = ifi1; ap = ifp1; an = ifn1;
                av = v1; ads = ds1; aae = ae1;
            end
            bad = (apc !== e.pc) || (anpc !== e.npc) || (ai !== e.instr) ||
                  (av !== e.v) || (ads !== e.ds) || (aae !== e.ae) ||
                  (e.ifa && ((ap !== e.ipc) || (an !== e.inpc)));
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL %s: got pc=%h npc=%h instr=%h ifpc=%h ifnpc=%h v=%b ds=%b ae=%b; want pc=%h npc=%h instr=%h ifpc=%h ifnpc=%h v=%b ds=%b ae=%b",
                         e.nm, apc, anpc, ai, ap, an, av, ads, aae,
                         e.pc, e.npc, e.instr, e.ipc, e.inpc, e.v, e.ds, e.ae);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        r0 = 1'b1; r1 = 1'b1; le = 1'b1; flush = 1'b0; sel = 2'b00; tag = '0; alu = '0;

        // Reset, boot bubble, sequential fetch
        tick("reset", 0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        r0 = 1'b0;
        tick("boot", 0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        tick("adv0", 0, 32'h4, 32'h8, 32'hA000_0000, 32'h0, 32'h4, 1, 0, 0, 1);
        tick("adv4", 0, 32'h8, 32'hC, 32'hA000_0004, 32'h4, 32'h8, 1, 0, 0, 1);

        // TAG redirect with one delay slot
        sel = 2'b01; tag = 32'h40;
        tick("tag_sel", 0, 32'hC, 32'h40, 32'hA000_0008, 32'h8, 32'hC, 1, 1, 0, 1);
        sel = 2'b00; tag = '0;
        tick("tag_slot", 0, 32'h40, 32'h44, 32'hA000_000C, 32'hC, 32'h40, 1, 0, 0, 1);
        tick("tag_tgt", 0, 32'h44, 32'h48, 32'hA000_0040, 32'h40, 32'h44, 1, 0, 0, 1);

        // Misaligned ALU target: aligned load, sticky error
        sel = 2'b10; alu = 32'h103;
        tick("alu_misal", 0, 32'h48, 32'h100, 32'hA000_0044, 32'h44, 32'h48, 1, 1, 1, 1);
        sel = 2'b00; alu = '0;
        tick("ae_sticky", 0, 32'h100, 32'h104, 32'hA000_0048, 32'h48, 32'h100, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            p = 32'h100 + 32'(4 * i);
            tick("ae_sticky", 0, p + 4, p + 8, 32'hA000_0000 + p, p, p + 4, 1, 0, 1, 1);
        end
        r0 = 1'b1;
        tick("ae_reset", 0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        r0 = 1'b0;
        tick("boot2", 0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            p = 32'(4 * k);
            tick("seq", 0, p + 4, p + 8, 32'hA000_0000 + p, p, p + 4, 1, 0, 0, 1);
        end

        // Stall at PC=0x20; a misaligned TAG during the stall must be ignored
        le = 1'b0; sel = 2'b01; tag = 32'h81;
        repeat (3) tick("stall", 0, 32'h20, 32'h24, 32'hA000_001C, 32'h1C, 32'h20, 1, 0, 0, 1);
        le = 1'b1; sel = 2'b00; tag = '0;
        tick("stall_resume", 0, 32'h24, 32'h28, 32'hA000_0020, 32'h20, 32'h24, 1, 0, 0, 1);
        for (int k = 9; k < 12; k++) begin
            p = 32'(4 * k);
            tick("seq2", 0, p + 4, p + 8, 32'hA000_0000 + p, p, p + 4, 1, 0, 0, 1);
        end

        // Flush while advancing: fetch continues, DS suppressed
        flush = 1'b1; sel = 2'b01; tag = 32'h60;
        tick("flush_adv", 0, 32'h34, 32'h60, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        flush = 1'b0; sel = 2'b10; alu = 32'h70;
        tick("alu_ds", 0, 32'h60, 32'h70, 32'hA000_0034, 32'h34, 32'h60, 1, 1, 0, 1);
        // Flush while stalled: PC/nPC hold, IF/ID cleared
        flush = 1'b1; le = 1'b0; sel = 2'b00; alu = '0;
        tick("flush_stall", 0, 32'h60, 32'h70, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        flush = 1'b0; le = 1'b1;
        tick("hold_resume", 0, 32'h70, 32'h74, 32'hA000_0060, 32'h60, 32'h70, 1, 0, 0, 1);
        // Reserved select behaves as nPC+4 and never flags alignment
        sel = 2'b11; tag = 32'h3; alu = 32'h3;
        tick("sel_rsvd", 0, 32'h74, 32'h78, 32'hA000_0070, 32'h70, 32'h74, 1, 0, 0, 1);
        sel = 2'b00; tag = '0; alu = '0;

        // Wrap-around on the second instance
        r0 = 1'b1; r1 = 1'b1;
        tick("wrap_reset", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        r1 = 1'b0;
        tick("wrap_boot", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        tick("wrap_a", 1, 32'hFFFF_FFFC, 32'h0, 32'h9FFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
             1, 0, 0, 1);
        tick("wrap_b", 1, 32'h0, 32'h4, 32'h9FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 1);
        tick("wrap_c", 1, 32'h4, 32'h8, 32'hA000_0000, 32'h0, 32'h4, 1, 0, 0, 1);
        le = 1'b0;
        repeat (2) tick("wrap_hold", 1, 32'h4, 32'h8, 32'hA000_0000, 32'h0, 32'h4, 1, 0, 0, 1);
        r1 = 1'b1;
        tick("hold_reset", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        r1 = 1'b0; le = 1'b1;
        tick("hold_reboot", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        tick("reboot_adv", 1, 32'hFFFF_FFFC, 32'h0, 32'h9FFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
             1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
